// File: rtl/vga_pixel_out_buffer.sv
// Pixel output FIFO: absorbs the bursty framebuffer stream and drains one pixel per pixel_ce.
// Optional VGA_PIXEL_OUT_STATS_EN adds a saturating underflow_count output.
module vga_pixel_out_buffer #(
  parameter int PIXEL_BITS  = 12,
  parameter int DEPTH       = 16,
  parameter int START_LEVEL = 8,
  parameter int SKID        = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pixel_ce,
  input  logic                  in_valid,
  input  logic                  in_visible,
  input  logic                  in_hsync,
  input  logic                  in_vsync,
  input  logic [PIXEL_BITS-1:0] in_color,
  output logic                  enable,
  output logic                  vga_hsync,
  output logic                  vga_vsync,
  output logic [PIXEL_BITS-1:0] vga_color,
  output logic                  running,
  output logic                  underflow,
`ifdef VGA_PIXEL_OUT_STATS_EN
  output logic [15:0]           underflow_count,
`endif
  output logic                  overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = PIXEL_BITS + 3;

  typedef enum logic {S_FILL, S_RUN} state_t;

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count, w_count_nxt;
  state_t        r_state, w_state_nxt;

  logic          w_full, w_pop, w_under, w_push, w_drop;
  logic [EW-1:0] w_rd;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = pixel_ce && (r_state == S_RUN) && (r_count != '0);
  assign w_under = pixel_ce && (r_state == S_RUN) && (r_count == '0);
  // A full FIFO still accepts a push when the same cycle pops.
  assign w_push  = in_valid && (!w_full || w_pop);
  assign w_drop  = in_valid && w_full && !w_pop;
  assign w_rd    = r_mem[r_rptr];
  assign running = (r_state == S_RUN);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL:  if (r_count >= CW'(START_LEVEL)) w_state_nxt = S_RUN;
      S_RUN:   if (w_under) w_state_nxt = S_FILL;
      default: w_state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {in_visible, in_hsync, in_vsync, in_color};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_state   <= S_FILL;
      enable    <= 1'b0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
      vga_color <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      enable    <= (w_count_nxt <= CW'(DEPTH - SKID));
      underflow <= w_under;
      if (w_drop) overflow <= 1'b1;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) begin
        r_rptr    <= r_rptr + AW'(1);
        vga_hsync <= w_rd[PIXEL_BITS+1];
        vga_vsync <= w_rd[PIXEL_BITS];
        vga_color <= w_rd[EW-1] ? w_rd[PIXEL_BITS-1:0] : '0;
      end else if (w_under) begin
        vga_hsync <= 1'b1;
        vga_vsync <= 1'b1;
        vga_color <= '0;
      end
    end
  end

`ifdef VGA_PIXEL_OUT_STATS_EN
  always_ff @(posedge clk) begin
    if (reset)                                         underflow_count <= '0;
    else if (underflow && underflow_count != 16'hFFFF) underflow_count <= underflow_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_vga_pixel_out_buffer.sv
// Directed bench for vga_pixel_out_buffer (DEPTH=16, START_LEVEL=8, SKID=3).
module tb_vga_pixel_out_buffer;
  logic        clk = 0, reset = 1, pixel_ce = 0, in_valid = 0;
  logic        in_visible = 0, in_hsync = 1, in_vsync = 1;
  logic [11:0] in_color = 0;
  logic        enable, vga_hsync, vga_vsync, running, underflow, overflow;
  logic [11:0] vga_color;
`ifdef VGA_PIXEL_OUT_STATS_EN
  logic [15:0] underflow_count;
`endif
  int checks = 0, failures = 0;

  vga_pixel_out_buffer #(.PIXEL_BITS(12), .DEPTH(16), .START_LEVEL(8), .SKID(3)) dut (
    .clk(clk), .reset(reset), .pixel_ce(pixel_ce), .in_valid(in_valid),
    .in_visible(in_visible), .in_hsync(in_hsync), .in_vsync(in_vsync), .in_color(in_color),
    .enable(enable), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_color(vga_color),
    .running(running), .underflow(underflow),
`ifdef VGA_PIXEL_OUT_STATS_EN
    .underflow_count(underflow_count),
`endif
    .overflow(overflow));

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1; pixel_ce = 0; in_valid = 0;
    cyc(); cyc();
    reset = 0;
    cyc();
  endtask

  task automatic push(input logic vis, input logic hs, input logic vs, input logic [11:0] col);
    in_valid = 1; in_visible = vis; in_hsync = hs; in_vsync = vs; in_color = col;
    cyc();
    in_valid = 0;
  endtask

  task automatic pop_one();
    pixel_ce = 1; cyc(); pixel_ce = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if ({enable, vga_hsync, vga_vsync, vga_color, running, underflow, overflow} !== {1'b0, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL reset_outputs got en=%b hs=%b vs=%b col=%h run=%b uf=%b of=%b", enable, vga_hsync, vga_vsync, vga_color, running, underflow, overflow);
      end
    end
`ifdef VGA_PIXEL_OUT_STATS_EN
    checks++;
    if (underflow_count !== 16'd0) begin failures++; $display("FAIL reset_ufcount got=%0d exp=0", underflow_count); end
`endif
    reset = 0;
    cyc();
    checks++;
    if (enable !== 1'b1) begin failures++; $display("FAIL enable_after_reset got=%b exp=1", enable); end
    for (int i = 0; i < 4; i++) begin
      pixel_ce = 1; cyc(); pixel_ce = 0;
      checks++;
      if (running !== 1'b0) begin failures++; $display("FAIL fill_idle got=%b exp=0", running); end
    end
  endtask

  task automatic test_fill_start();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1; in_visible = 1; in_hsync = 1; in_vsync = 1; in_color = 12'(i + 1);
      pixel_ce = (i % 4 == 3);
      cyc();
    end
    in_valid = 0; pixel_ce = 0;
    checks++;
    if (running !== 1'b0) begin failures++; $display("FAIL run_early got=%b exp=0", running); end
    cyc();
    checks++;
    if (running !== 1'b1) begin failures++; $display("FAIL run_rise got=%b exp=1", running); end
    for (int i = 1; i <= 8; i++) begin
      pop_one();
      checks++;
      if (vga_color !== 12'(i)) begin failures++; $display("FAIL fill_order got=%h exp=%h", vga_color, 12'(i)); end
      cyc(); cyc(); cyc();
    end
    checks++;
    if (vga_color !== 12'h008) begin failures++; $display("FAIL pin_hold got=%h exp=008", vga_color); end
  endtask

  task automatic test_blanking_underflow();
    int pulses;
    do_reset();
    push(1'b0, 1'b0, 1'b1, 12'hFFF);
    for (int i = 0; i < 7; i++) push(1'b1, 1'b1, 1'b1, 12'h0A0 + 12'(i));
    cyc(); cyc();
    pop_one();
    checks++;
    if ({vga_hsync, vga_vsync, vga_color} !== {1'b0, 1'b1, 12'h000}) begin
      failures++; $display("FAIL blanking got hs=%b vs=%b col=%h exp hs=0 vs=1 col=000", vga_hsync, vga_vsync, vga_color);
    end
    for (int i = 0; i < 7; i++) begin
      pop_one();
      checks++;
      if ({vga_hsync, vga_color} !== {1'b1, 12'h0A0 + 12'(i)}) begin
        failures++; $display("FAIL blank_next got hs=%b col=%h exp hs=1 col=%h", vga_hsync, vga_color, 12'h0A0 + 12'(i));
      end
    end
    pulses = 0;
    for (int j = 0; j < 8; j++) begin
      pixel_ce = (j % 2 == 0); cyc();
      if (underflow === 1'b1) pulses++;
    end
    pixel_ce = 0;
    checks++;
    if (pulses !== 1) begin failures++; $display("FAIL underflow_pulses got=%0d exp=1", pulses); end
    checks++;
    if ({running, vga_hsync, vga_vsync, vga_color} !== {1'b0, 1'b1, 1'b1, 12'h000}) begin
      failures++; $display("FAIL underflow_idle got run=%b hs=%b vs=%b col=%h", running, vga_hsync, vga_vsync, vga_color);
    end
`ifdef VGA_PIXEL_OUT_STATS_EN
    checks++;
    if (underflow_count !== 16'd1) begin failures++; $display("FAIL ufcount got=%0d exp=1", underflow_count); end
`endif
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      push(1'b1, 1'b1, 1'b1, 12'h100 + 12'(n));
      n++;
      checks++;
      if (enable !== (n <= 13)) begin failures++; $display("FAIL enable_level count=%0d got=%b exp=%b", n, enable, (n <= 13)); end
      if (enable !== 1'b1) break;
    end
    checks++;
    if (n !== 14) begin failures++; $display("FAIL enable_fall_at got=%0d exp=14", n); end
    for (int i = 0; i < 2; i++) begin
      push(1'b1, 1'b1, 1'b1, 12'h100 + 12'(n)); n++;
      checks++;
      if (overflow !== 1'b0) begin failures++; $display("FAIL skid_no_overflow got=%b exp=0", overflow); end
    end
    push(1'b1, 1'b1, 1'b1, 12'h1FE);
    push(1'b1, 1'b1, 1'b1, 12'h1FF);
    checks++;
    if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_set got=%b exp=1", overflow); end
    checks++;
    if (running !== 1'b1) begin failures++; $display("FAIL bp_running got=%b exp=1", running); end
    for (int i = 0; i < 16; i++) begin
      pop_one();
      checks++;
      if (vga_color !== 12'h100 + 12'(i)) begin failures++; $display("FAIL bp_drain got=%h exp=%h", vga_color, 12'h100 + 12'(i)); end
    end
    pop_one();
    checks++;
    if (underflow !== 1'b1) begin failures++; $display("FAIL bp_dropped_gone got uf=%b exp=1", underflow); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL reset_clears_overflow got=%b exp=0", overflow); end
    for (int i = 0; i < 16; i++) push(1'b1, 1'b1, 1'b1, 12'h200 + 12'(i));
    cyc();
    checks++;
    if (running !== 1'b1) begin failures++; $display("FAIL full_running got=%b exp=1", running); end
    in_valid = 1; in_color = 12'h2AA; pixel_ce = 1;
    cyc();
    in_valid = 0; pixel_ce = 0;
    checks++;
    if ({vga_color, overflow, enable} !== {12'h200, 1'b0, 1'b0}) begin
      failures++; $display("FAIL full_pushpop got col=%h of=%b en=%b exp col=200 of=0 en=0", vga_color, overflow, enable);
    end
    for (int i = 1; i <= 16; i++) begin
      pop_one();
      checks++;
      if ({vga_color, underflow} !== {(i == 16) ? 12'h2AA : 12'h200 + 12'(i), 1'b0}) begin
        failures++; $display("FAIL full_drain idx=%0d got col=%h uf=%b", i, vga_color, underflow);
      end
    end
    pop_one();
    checks++;
    if ({underflow, overflow} !== 2'b10) begin failures++; $display("FAIL full_end got uf=%b of=%b exp uf=1 of=0", underflow, overflow); end
  endtask

  initial begin
    test_reset();
    test_fill_start();
    test_blanking_underflow();
    test_backpressure();
    test_full_push_pop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
